mem_io_responder: RTL and testbench
===================================

Name: mem_io_responder

Overview:
- Target-side model of the CPU byte memory bus: 128 KB RAM plus the memory-mapped I/O window.
- Answers the CPU's address/data/write strobe with registered read data one cycle later.
- Buffers UART receive and transmit bytes, exposes a cycle counter, and latches program stop.
- Drives the CPU pause input, so a full transmit buffer never drops a byte.

Parameters:
RAM_ADDR_W, 17, RAM byte address width (2^17 = 128 KB)
RX_DEPTH, 16, receive FIFO entries (power of 2, >=2)
TX_DEPTH, 16, transmit FIFO entries (power of 2, >=2)

Ports:
clk_in  in  1  system clock
rst_in  in  1  synchronous reset, active high
cpu_a  in  32  CPU address; only [17:0] decoded
cpu_dout  in  8  CPU write data
cpu_wr  in  1  1 = write, 0 = read
cpu_din  out  8  read data to CPU, registered
cpu_rdy  out  1  CPU run enable; low pauses the CPU
rx_valid  in  1  incoming UART byte valid
rx_data  in  8  incoming UART byte
rx_ready  out  1  receive FIFO not full
tx_valid  out  1  transmit FIFO not empty
tx_data  out  8  head of transmit FIFO
tx_ready  in  1  UART accepts tx_data
prog_stop  out  1  sticky program-stop flag

Behaviour:
- Clock/reset: one clock, clk_in. Reset is synchronous, active high, on rst_in.
- Reset values: cpu_din=0, cpu_rdy=1, rx_ready=1, tx_valid=0, prog_stop=0, cycle counter=0, counter snapshot=0, both FIFOs empty. RAM contents are not cleared.
- Access qualification: an access counts only in a cycle with cpu_rdy=1. When cpu_rdy=0, cpu_wr and cpu_a are ignored and cpu_din holds its value.
- Address decode on cpu_a[17:16]:
  - 00/01: RAM at cpu_a[16:0].
  - 10: unmapped; writes dropped, reads return 0x00.
  - 11: I/O window.
- RAM write: RAM[a] <= cpu_dout at the clock edge; no wait state. RAM read: cpu_din <= RAM[a] on the next edge (latency 1). Write in cycle N followed by read of the same address in N+1 returns the new byte.
- I/O read, a[2:0]=000: cpu_din <= receive FIFO head and the entry is popped. If the FIFO is empty, return 0x00 with no pop.
- I/O read, a[2:0]=100..111: return byte a[1:0] of the counter snapshot, little-endian.
  - A read at 100 loads the snapshot from the live counter and returns byte 0 of the live value in the same access.
  - Reads at 101/110/111 return the snapshot unchanged, so a 4-byte read is coherent.
- Other I/O offsets: reads return 0x00; writes are ignored.
- Cycle counter: 32-bit, +1 every clock while cpu_rdy=1, wraps 0xFFFFFFFF -> 0.
- I/O write, a[2:0]=000: push cpu_dout to the transmit FIFO, except 0x00, which is dropped.
- I/O write, a[2:0]=100: push 0x00 to the transmit FIFO and set prog_stop=1 (sticky until reset).
- Transmit FIFO:
  - Pop when tx_valid && tx_ready.
  - Push and pop in the same cycle are both performed.
  - cpu_rdy = !tx_full && !prog_stop (combinational), so a write can never target a full FIFO.
  - After stop, the CPU stays paused while the FIFO drains.
- Receive FIFO:
  - Push when rx_valid && rx_ready.
  - A simultaneous push and pop on a full FIFO is accepted: rx_ready = !full || pop_this_cycle.
  - A push into an empty FIFO is readable by the CPU one cycle later, not in the same cycle.
- Reset mid-access: a pending read is discarded and cpu_din=0 after reset. A FIFO push or pop in the reset cycle is lost.

Optional Feature:
- MEM_IO_BOUNDS_CHECK_EN
  - Defined: adds output bus_err (1 bit, reset 0). bus_err sets sticky on any qualified access to the unmapped region (a[17:16]=10) or an undefined I/O offset. A $display warning is issued in simulation.
  - Undefined: no bus_err port, and those accesses are silently ignored as described above.

Decomposition:
- Package mem_io_pkg holds:
  - IO_UART_OFF=3'b000, IO_CLK_OFF=3'b100.
  - Region codes REG_RAM0/RAM1/UNMAP/IO for a[17:16].
  - BYTE_W=8, CNT_W=32.
- Sub-module: sync_byte_fifo (parameters DEPTH; ports push/pop/din/dout/full/empty/count; dout shows the head combinationally). Instantiated twice, once for receive and once for transmit. RAM and decode stay in mem_io_responder.

Test Plan:
- RAM: write 0x5A to 0x00123, read 0x00123 next cycle -> cpu_din=0x5A one cycle after the read; read 0x1FFFF after write 0xC3 -> 0xC3.
- UART tx filtering: write 0x41, 0x00, 0x42 to 0x30000 with tx_ready=1 -> tx stream is exactly 0x41, 0x42.
- Transmit backpressure: tx_ready=0, write 16 bytes to 0x30000 -> cpu_rdy falls after the 16th. A 17th write held while paused is not enqueued. Pulse tx_ready once -> cpu_rdy=1 next cycle.
- Receive path:
  - Push 0x31, 0x32 via rx -> two reads of 0x30000 return 0x31, 0x32, and a third read returns 0x00.
  - Fill 16 entries -> rx_ready=0.
- Cycle counter: after 300 cycles from reset, read 0x30004..0x30007 on consecutive cycles -> bytes form 0x0000012C+offset, taken from the snapshot at the 0x30004 read, with no tearing. Also preload near 0xFFFFFFFF via force -> wrap to 0.
- Stop: write any byte to 0x30004 -> tx emits 0x00, prog_stop=1, cpu_rdy=0 and held. rst_in=1 for one cycle -> prog_stop=0, cpu_rdy=1, FIFOs empty, RAM contents retained.

Source files
------------

// File: rtl/mem_io_pkg.sv
// Shared constants for the CPU byte-bus responder: I/O offsets, region codes and widths.
package mem_io_pkg;

   localparam int BYTE_W = 8;
   localparam int CNT_W  = 32;

   localparam logic [2:0] IO_UART_OFF = 3'b000;
   localparam logic [2:0] IO_CLK_OFF  = 3'b100;

   typedef enum logic [1:0] {
      REG_RAM0  = 2'b00,
      REG_RAM1  = 2'b01,
      REG_UNMAP = 2'b10,
      REG_IO    = 2'b11
   } region_e;

   // Little-endian byte select out of a counter word.
   function automatic logic [BYTE_W-1:0] cnt_byte(input logic [CNT_W-1:0] v, input logic [1:0] sel);
      return v[int'(sel)*BYTE_W +: BYTE_W];
   endfunction

endpackage

// File: rtl/sync_byte_fifo.sv
// Synchronous byte FIFO with combinational head; a push into a full FIFO is taken
// only when a pop happens in the same cycle.
module sync_byte_fifo
   import mem_io_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    push,
   input  logic                    pop,
   input  logic [BYTE_W-1:0]       din,
   output logic [BYTE_W-1:0]       dout,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int AW = $clog2(DEPTH);

   logic [BYTE_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     rd_ptr_q, wr_ptr_q;
   logic [AW:0]       count_q;
   logic              do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = count_q[AW];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem_q[rd_ptr_q];
   assign count   = count_q;

   // NOTE: storage is deliberately not reset; only the pointers define validity.
   always_ff @(posedge clk_in) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/mem_io_responder.sv
// Target side of the CPU byte bus: 128 KB RAM, UART FIFOs, cycle counter and program stop.
// Optional MEM_IO_BOUNDS_CHECK_EN adds a sticky bus_err output for unmapped/undefined accesses.
module mem_io_responder
   import mem_io_pkg::*;
#(
   parameter int RAM_ADDR_W = 17,
   parameter int RX_DEPTH   = 16,
   parameter int TX_DEPTH   = 16
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic [31:0]       cpu_a,
   input  logic [BYTE_W-1:0] cpu_dout,
   input  logic              cpu_wr,
   output logic [BYTE_W-1:0] cpu_din,
   output logic              cpu_rdy,
   input  logic              rx_valid,
   input  logic [BYTE_W-1:0] rx_data,
   output logic              rx_ready,
   output logic              tx_valid,
   output logic [BYTE_W-1:0] tx_data,
   input  logic              tx_ready,
`ifdef MEM_IO_BOUNDS_CHECK_EN
   output logic              bus_err,
`endif
   output logic              prog_stop
);

   localparam int RX_CW = $clog2(RX_DEPTH) + 1;
   localparam int TX_CW = $clog2(TX_DEPTH) + 1;

   logic [BYTE_W-1:0]     ram_q [2**RAM_ADDR_W];
   logic [RAM_ADDR_W-1:0] ram_addr;
   region_e               region;
   logic [2:0]            io_off;
   logic                  rd_acc, wr_acc, ram_we;

   logic [BYTE_W-1:0] cpu_din_q, cpu_din_d;
   logic [CNT_W-1:0]  cnt_q, snap_q, snap_d;
   logic              stop_q, stop_d;

   logic              rx_pop, rx_push, rx_full, rx_empty;
   logic [BYTE_W-1:0] rx_dout;
   logic [RX_CW-1:0]  rx_count;
   logic              tx_push, tx_pop, tx_full, tx_empty;
   logic [BYTE_W-1:0] tx_din;
   logic [TX_CW-1:0]  tx_count;

   assign region   = region_e'(cpu_a[17:16]);
   assign io_off   = cpu_a[2:0];
   assign ram_addr = cpu_a[RAM_ADDR_W-1:0];

   // A paused CPU issues no access, so pausing on a full TX FIFO guarantees no byte is dropped.
   assign cpu_rdy  = !tx_full && !stop_q;
   assign rd_acc   = cpu_rdy && !cpu_wr;
   assign wr_acc   = cpu_rdy && cpu_wr;
   assign ram_we   = wr_acc && !rst_in && (region == REG_RAM0 || region == REG_RAM1);

   always_ff @(posedge clk_in) begin
      if (ram_we) ram_q[ram_addr] <= cpu_dout;
   end

   assign rx_pop   = rd_acc && region == REG_IO && io_off == IO_UART_OFF && !rx_empty;
   assign rx_ready = !rx_full || rx_pop;
   assign rx_push  = rx_valid && rx_ready;

   assign tx_push  = wr_acc && region == REG_IO &&
                     ((io_off == IO_UART_OFF && cpu_dout != '0) || io_off == IO_CLK_OFF);
   assign tx_din   = (io_off == IO_CLK_OFF) ? '0 : cpu_dout;
   assign tx_pop   = tx_valid && tx_ready;
   assign tx_valid = !tx_empty;

   sync_byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk_in(clk_in), .rst_in(rst_in), .push(rx_push), .pop(rx_pop), .din(rx_data),
      .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
   );

   sync_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk_in(clk_in), .rst_in(rst_in), .push(tx_push), .pop(tx_pop), .din(tx_din),
      .dout(tx_data), .full(tx_full), .empty(tx_empty), .count(tx_count)
   );

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      cpu_din_d = cpu_din_q;
      snap_d    = snap_q;
      stop_d    = stop_q;
      if (rd_acc) begin
         unique case (region)
            REG_RAM0, REG_RAM1: cpu_din_d = ram_q[ram_addr];
            REG_UNMAP:          cpu_din_d = '0;
            REG_IO: begin
               if (io_off == IO_UART_OFF) begin
                  cpu_din_d = rx_empty ? '0 : rx_dout;
               end else if (io_off == IO_CLK_OFF) begin
                  // Snapshot and byte 0 come from the same live value, keeping the 4-byte read coherent.
                  snap_d    = cnt_q;
                  cpu_din_d = cnt_q[BYTE_W-1:0];
               end else if (io_off[2]) begin
                  cpu_din_d = cnt_byte(snap_q, io_off[1:0]);
               end else begin
                  cpu_din_d = '0;
               end
            end
         endcase
      end
      if (wr_acc && region == REG_IO && io_off == IO_CLK_OFF) stop_d = 1'b1;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         cpu_din_q <= '0;
         cnt_q     <= '0;
         snap_q    <= '0;
         stop_q    <= 1'b0;
      end else begin
         cpu_din_q <= cpu_din_d;
         snap_q    <= snap_d;
         stop_q    <= stop_d;
         if (cpu_rdy) cnt_q <= cnt_q + 1'b1;
      end
   end

   assign cpu_din   = cpu_din_q;
   assign prog_stop = stop_q;

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         assert (rx_count <= RX_CW'(RX_DEPTH) && tx_count <= TX_CW'(TX_DEPTH));
         if (cpu_rdy) assert (!$isunknown({cpu_a, cpu_wr, cpu_dout}));
      end
   end

`ifdef MEM_IO_BOUNDS_CHECK_EN
   logic bad_acc, bus_err_q;

   always_comb begin
      bad_acc = 1'b0;
      if (cpu_rdy && region == REG_UNMAP) bad_acc = 1'b1;
      if (rd_acc && region == REG_IO && io_off inside {3'b001, 3'b010, 3'b011}) bad_acc = 1'b1;
      if (wr_acc && region == REG_IO && !(io_off inside {IO_UART_OFF, IO_CLK_OFF})) bad_acc = 1'b1;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         bus_err_q <= 1'b0;
      end else if (bad_acc) begin
         bus_err_q <= 1'b1;
`ifndef SYNTHESIS
         $warning("mem_io_responder: bad access a=%h wr=%b", cpu_a, cpu_wr);
`endif
      end
   end

   assign bus_err = bus_err_q;
`endif

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: directed scenarios plus random traffic
// compared against a queue/array-based reference model.
module tb_mem_io_responder;

   localparam int          TXD  = 16;
   localparam int          RXD  = 16;
   localparam logic [31:0] IDLE = 32'h0003_0001;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [31:0] cpu_a;
   logic [7:0]  cpu_dout;
   logic        cpu_wr;
   logic [7:0]  cpu_din;
   logic        cpu_rdy;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        prog_stop;
`ifdef MEM_IO_BOUNDS_CHECK_EN
   logic        bus_err;
`endif

   always #5 clk_in = ~clk_in;

   mem_io_responder #(.RAM_ADDR_W(17), .RX_DEPTH(RXD), .TX_DEPTH(TXD)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_wr(cpu_wr),
      .cpu_din(cpu_din), .cpu_rdy(cpu_rdy), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_ready(rx_ready), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
`ifdef MEM_IO_BOUNDS_CHECK_EN
      .bus_err(bus_err),
`endif
      .prog_stop(prog_stop)
   );

   // Reference model state
   logic [7:0]  m_ram [int];
   logic [7:0]  m_rxq [$];
   logic [7:0]  m_txq [$];
   logic [31:0] m_cnt, m_snap;
   logic        m_stop;
   logic [7:0]  m_din;
   bit          m_din_known;
   int          addrs [$];
   logic [7:0]  dut_tx_log [$];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One bus cycle: called at a falling edge, returns at the next falling edge.
   task automatic tick(input logic [31:0] a, input logic wr, input logic [7:0] d,
                       input logic rxv, input logic [7:0] rxd, input logic txr);
      bit         rdy, rd_q, wr_q, rx_pop, rx_rdy;
      logic [1:0] rg;
      logic [2:0] off;
      if (m_din_known) check("cpu_din", 32'(cpu_din), 32'(m_din));
      check("prog_stop", 32'(prog_stop), 32'(m_stop));
      cpu_a = a; cpu_wr = wr; cpu_dout = d; rx_valid = rxv; rx_data = rxd; tx_ready = txr;
      #1;
      rg     = a[17:16];
      off    = a[2:0];
      rdy    = (m_txq.size() < TXD) && !m_stop;
      rd_q   = rdy && !wr;
      wr_q   = rdy && wr;
      rx_pop = rd_q && rg == 2'b11 && off == 3'd0 && m_rxq.size() > 0;
      rx_rdy = (m_rxq.size() < RXD) || rx_pop;
      check("cpu_rdy", 32'(cpu_rdy), 32'(rdy));
      check("rx_ready", 32'(rx_ready), 32'(rx_rdy));
      check("tx_valid", 32'(tx_valid), 32'(m_txq.size() > 0));
      if (m_txq.size() > 0) check("tx_data", 32'(tx_data), 32'(m_txq[0]));
      if (tx_valid && txr) dut_tx_log.push_back(tx_data);

      if (m_txq.size() > 0 && txr) void'(m_txq.pop_front());
      if (rd_q) begin
         m_din_known = 1'b1;
         if (rg[1] == 1'b0)      m_din = m_ram[int'(a[16:0])];
         else if (rg == 2'b10)   m_din = 8'h00;
         else if (off == 3'd0)   m_din = rx_pop ? m_rxq.pop_front() : 8'h00;
         else if (off == 3'd4) begin
            m_snap = m_cnt;
            m_din  = m_cnt[7:0];
         end else if (off > 3'd4) m_din = 8'(m_snap >> (8 * (int'(off) - 4)));
         else                     m_din = 8'h00;
      end
      if (wr_q) begin
         m_din_known = 1'b0;
         if (rg[1] == 1'b0) begin
            m_ram[int'(a[16:0])] = d;
            addrs.push_back(int'(a[16:0]));
         end else if (rg == 2'b11 && off == 3'd0 && d != 8'h00) begin
            m_txq.push_back(d);
         end else if (rg == 2'b11 && off == 3'd4) begin
            m_txq.push_back(8'h00);
            m_stop = 1'b1;
         end
      end
      if (rxv && rx_rdy) m_rxq.push_back(rxd);
      if (rdy) m_cnt = m_cnt + 32'd1;
      @(posedge clk_in);
      @(negedge clk_in);
   endtask

   task automatic do_reset(input logic [31:0] a, input logic rxv);
      rst_in = 1'b1; cpu_a = a; cpu_wr = 1'b0; cpu_dout = 8'h00;
      rx_valid = rxv; rx_data = 8'hEE; tx_ready = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);
      rst_in = 1'b0; cpu_a = IDLE; rx_valid = 1'b0; tx_ready = 1'b0;
      m_rxq.delete(); m_txq.delete();
      m_cnt = '0; m_snap = '0; m_stop = 1'b0; m_din = 8'h00; m_din_known = 1'b1;
      #1;
      check("rst_cpu_din", 32'(cpu_din), 32'h00);
      check("rst_cpu_rdy", 32'(cpu_rdy), 32'h1);
      check("rst_rx_ready", 32'(rx_ready), 32'h1);
      check("rst_tx_valid", 32'(tx_valid), 32'h0);
      check("rst_prog_stop", 32'(prog_stop), 32'h0);
   endtask

   task automatic read_cnt(output logic [31:0] v);
      for (int i = 0; i < 4; i++) begin
         tick(32'h0003_0004 + 32'(i), 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
         v[8*i +: 8] = cpu_din;
      end
   endtask

   task automatic drain_tx();
      for (int i = 0; i < TXD + 4; i++) tick(IDLE, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] v;
      logic [31:0] a;
      logic        w;
      logic [7:0]  d;
      int          op;

      @(negedge clk_in);
      do_reset(IDLE, 1'b0);

      // Counter snapshot after 300 cycles, coherent 4-byte read
      repeat (300) tick(IDLE, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      read_cnt(v);
      check("cnt_300", v, 32'h0000_012C);

      // RAM write/read back-to-back, top address, unmapped isolation, upper-bit aliasing
      tick(32'h0000_0123, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b1);
      tick(32'h0000_0123, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      check("ram_0123", 32'(cpu_din), 32'h5A);
      tick(32'h0001_FFFF, 1'b1, 8'hC3, 1'b0, 8'h00, 1'b1);
      tick(32'h0001_FFFF, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      check("ram_1ffff", 32'(cpu_din), 32'hC3);
      tick(32'h0002_0123, 1'b1, 8'h77, 1'b0, 8'h00, 1'b1);
      tick(32'h0002_0123, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      check("unmapped_rd", 32'(cpu_din), 32'h00);
      tick(32'hABC0_0123, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      check("ram_alias", 32'(cpu_din), 32'h5A);

      // TX filtering of zero bytes
      dut_tx_log.delete();
      tick(32'h0003_0000, 1'b1, 8'h41, 1'b0, 8'h00, 1'b1);
      tick(32'h0003_0000, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1);
      tick(32'h0003_0000, 1'b1, 8'h42, 1'b0, 8'h00, 1'b1);
      drain_tx();
      check("tx_filt_len", 32'(dut_tx_log.size()), 32'd2);
      if (dut_tx_log.size() == 2) begin
         check("tx_filt_0", 32'(dut_tx_log[0]), 32'h41);
         check("tx_filt_1", 32'(dut_tx_log[1]), 32'h42);
      end

      // TX backpressure: 16 bytes fill the FIFO, extra writes while paused are dropped
      dut_tx_log.delete();
      for (int i = 0; i < TXD; i++) tick(32'h0003_0000, 1'b1, 8'h60 + 8'(i), 1'b0, 8'h00, 1'b0);
      check("bp_paused", 32'(cpu_rdy), 32'h0);
      repeat (2) tick(32'h0003_0000, 1'b1, 8'h99, 1'b0, 8'h00, 1'b0);
      tick(IDLE, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      check("bp_resume", 32'(cpu_rdy), 32'h1);
      drain_tx();
      check("bp_len", 32'(dut_tx_log.size()), 32'(TXD));
      for (int i = 0; i < TXD && i < dut_tx_log.size(); i++)
         check("bp_byte", 32'(dut_tx_log[i]), 32'(8'h60 + 8'(i)));

      // RX path: ordering, empty read, one-cycle visibility, full and full+pop
      tick(IDLE, 1'b0, 8'h00, 1'b1, 8'h31, 1'b1);
      tick(IDLE, 1'b0, 8'h00, 1'b1, 8'h32, 1'b1);
      tick(32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      check("rx_rd0", 32'(cpu_din), 32'h31);
      tick(32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      check("rx_rd1", 32'(cpu_din), 32'h32);
      tick(32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h55, 1'b1);
      check("rx_rd_empty", 32'(cpu_din), 32'h00);
      tick(32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      check("rx_rd_late", 32'(cpu_din), 32'h55);
      for (int i = 0; i < RXD; i++) tick(IDLE, 1'b0, 8'h00, 1'b1, 8'h80 + 8'(i), 1'b1);
      check("rx_full", 32'(rx_ready), 32'h0);
      tick(32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b1);
      for (int i = 0; i < RXD; i++) tick(32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      check("rx_full_pop", 32'(cpu_din), 32'hA5);

      // Counter wrap with snapshot coherence across the wrap
      force dut.cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.cnt_q;
      m_cnt = 32'hFFFF_FFFE;
      tick(IDLE, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      read_cnt(v);
      check("cnt_pre_wrap", v, 32'hFFFF_FFFF);
      read_cnt(v);
      check("cnt_wrapped", v, 32'h0000_0003);

      // Random traffic against the model
      for (int n = 0; n < 600; n++) begin
         op = $urandom_range(0, 9);
         a  = $urandom;
         d  = 8'($urandom);
         if ($urandom_range(0, 3) == 0) d = 8'h00;
         w  = 1'b0;
         if ((op == 2 || op == 3) && addrs.size() == 0) op = 0;
         case (op)
            0, 1: begin
               w = 1'b1; a[17] = 1'b0;
               if (a[16:0] == 17'h00123 || a[16:0] == 17'h1FFFF) a[16:0] = 17'h00400;
            end
            2, 3: begin
               a[17] = 1'b0;
               a[16:0] = 17'(addrs[$urandom_range(0, addrs.size() - 1)]);
            end
            4:    begin a[17:16] = 2'b10; w = 1'($urandom_range(0, 1)); end
            5, 6: begin a[17:16] = 2'b11; a[2:0] = 3'd0; w = 1'($urandom_range(0, 1)); end
            7:    begin a[17:16] = 2'b11; a[2:0] = 3'd4 + 3'($urandom_range(0, 3)); end
            8: begin
               a[17:16] = 2'b11;
               a[2:0] = 3'($urandom_range(1, 3));
               if ($urandom_range(0, 1) == 1) a[2] = 1'b1;
               w = 1'($urandom_range(0, 1));
            end
            default: a = IDLE;
         endcase
         tick(a, w, d, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      end
      drain_tx();

      // Program stop: emits 0x00, pauses the CPU and holds
      dut_tx_log.delete();
      tick(32'h0003_0004, 1'b1, 8'h77, 1'b0, 8'h00, 1'b0);
      check("stop_flag", 32'(prog_stop), 32'h1);
      check("stop_paused", 32'(cpu_rdy), 32'h0);
      repeat (3) tick(32'h0003_0000, 1'b1, 8'h55, 1'b0, 8'h00, 1'b1);
      repeat (2) tick(IDLE, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      check("stop_tx_len", 32'(dut_tx_log.size()), 32'd1);
      if (dut_tx_log.size() > 0) check("stop_tx_byte", 32'(dut_tx_log[0]), 32'h00);
      check("stop_held", 32'(cpu_rdy), 32'h0);

      // Reset mid-read with an RX push: read discarded, push lost, RAM retained
      do_reset(32'h0000_0123, 1'b1);
      tick(32'h0000_0123, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      check("ram_retained", 32'(cpu_din), 32'h5A);
      tick(32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      check("rx_rst_lost", 32'(cpu_din), 32'h00);
      tick(IDLE, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
